wb_mem_tester: RTL and testbench

//   Wishbone classic master that checks a Wishbone memory slave (e.g. the block RAM).
//   On start it writes nwords words of an incrementing pattern from base_adr,

---
 rtl/wb_mem_tester.sv | 176 +++++++++++++++++
 tb/tb_wb_mem_tester.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_tester
// Purpose  : Wishbone classic master that writes an incrementing pattern to a
//            memory slave, reads it back and reports mismatches.
// Revision : 1.0
// ============================================================================
module wb_mem_tester #(
   parameter int ADR_WIDTH = 32,
   parameter int CNT_WIDTH = 12,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADR_WIDTH-1:0] base_adr,
   input  logic [CNT_WIDTH-1:0] nwords,
   input  logic [31:0]          seed,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [15:0]          err_cnt,
   output logic [ADR_WIDTH-1:0] first_err_adr,
   output logic                 wb_cyc,
   output logic                 wb_stb,
   output logic                 wb_we,
   output logic [3:0]           wb_sel,
   output logic [ADR_WIDTH-1:0] wb_adr,
   output logic [31:0]          wb_dat_ms,
   input  logic [31:0]          wb_dat_sm,
   input  logic                 wb_ack
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_GAP   = 3'd2,
      S_READ  = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [ADR_WIDTH-1:0] base_q, base_d;
   logic [CNT_WIDTH-1:0] nwords_q, nwords_d;
   logic [CNT_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]          seed_q, seed_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [15:0]          err_cnt_q, err_cnt_d;
   logic [ADR_WIDTH-1:0] ferr_q, ferr_d;
   logic                 timeout_q, timeout_d;

   logic [ADR_WIDTH-1:0] w_cur_adr;
   logic [31:0]          w_cur_dat;
   logic                 w_in_bus;
   logic                 w_ack;
   logic                 w_last;
   logic                 w_expire;

   assign w_cur_adr = base_q + ADR_WIDTH'({idx_q, 2'b00});
   assign w_cur_dat = seed_q + 32'(idx_q);
   assign w_in_bus  = (state_q == S_WRITE) || (state_q == S_READ);
   assign w_ack     = w_in_bus && wb_ack;
   assign w_last    = (idx_q == (nwords_q - CNT_WIDTH'(1)));
   assign w_expire  = (wait_q == WAIT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         nwords_q  <= '0;
         idx_q     <= '0;
         seed_q    <= '0;
         wait_q    <= '0;
         err_cnt_q <= '0;
         ferr_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         nwords_q  <= nwords_d;
         idx_q     <= idx_d;
         seed_q    <= seed_d;
         wait_q    <= wait_d;
         err_cnt_q <= err_cnt_d;
         ferr_q    <= ferr_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      nwords_d  = nwords_q;
      idx_d     = idx_q;
      seed_d    = seed_q;
      wait_d    = wait_q;
      err_cnt_d = err_cnt_q;
      ferr_d    = ferr_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d    = base_adr & ~ADR_WIDTH'(3);
               nwords_d  = nwords;
               seed_d    = seed;
               idx_d     = '0;
               wait_d    = '0;
               err_cnt_d = '0;
               ferr_d    = '0;
               timeout_d = 1'b0;
               state_d   = (nwords == '0) ? S_FIN : S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_ack) begin
               wait_d = '0;
               if (w_last) begin
                  idx_d   = '0;
                  state_d = S_GAP;
               end else begin
                  idx_d = idx_q + CNT_WIDTH'(1);
               end
            end else if (w_expire) begin
               timeout_d = 1'b1;
               state_d   = S_FIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_GAP: begin
            idx_d   = '0;
            wait_d  = '0;
            state_d = S_READ;
         end
         S_READ: begin
            if (w_ack) begin
               wait_d = '0;
               if (wb_dat_sm != w_cur_dat) begin
                  // err_cnt never returns to zero within a run, so zero marks the first miss
                  if (err_cnt_q == 16'h0000) ferr_d = w_cur_adr;
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
               end
               if (w_last) state_d = S_FIN;
               else        idx_d   = idx_q + CNT_WIDTH'(1);
            end else if (w_expire) begin
               timeout_d = 1'b1;
               state_d   = S_FIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FIN);
   assign timeout       = timeout_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_adr = ferr_q;
   assign wb_cyc        = w_in_bus;
   assign wb_stb        = w_in_bus;
   assign wb_we         = (state_q == S_WRITE);
   assign wb_sel        = w_in_bus ? 4'hF : 4'h0;
   assign wb_adr        = w_in_bus ? w_cur_adr : '0;
   assign wb_dat_ms     = (state_q == S_WRITE) ? w_cur_dat : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_tester.sv
`default_nettype none
// Bench for wb_mem_tester: behavioural memory slave, bus scoreboard and
// table-driven runs plus timeout and mid-run reset sequences.
module tb_wb_mem_tester;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_adr;
   logic [11:0] nwords;
   logic [31:0] seed;
   logic        busy, done, timeout;
   logic [15:0] err_cnt;
   logic [31:0] first_err_adr;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
   logic        wb_ack;

   wb_mem_tester #(.ADR_WIDTH(32), .CNT_WIDTH(12), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
      .nwords(nwords), .seed(seed), .busy(busy), .done(done),
      .timeout(timeout), .err_cnt(err_cnt), .first_err_adr(first_err_adr),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms), .wb_dat_sm(wb_dat_sm),
      .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   // Slave: combinational write ack, registered read ack, optional read corruption.
   logic [31:0] mem [0:1023];
   logic        rd_ack_q = 1'b0;
   logic        no_ack;
   logic [31:0] cur_base;
   logic [31:0] corrupt_mask;
   logic [31:0] rd_off;

   always @(posedge clk) begin
      rd_ack_q <= wb_cyc & wb_stb & ~wb_we;
      if (wb_cyc && wb_stb && wb_we && wb_ack) mem[wb_adr[11:2]] <= wb_dat_ms;
   end

   assign rd_off    = (wb_adr - cur_base) >> 2;
   assign wb_dat_sm = mem[wb_adr[11:2]] ^
                      ((rd_off < 32) ? {31'b0, corrupt_mask[rd_off[4:0]]} : 32'b0);
   assign wb_ack    = no_ack ? 1'b0 : (wb_we ? (wb_cyc & wb_stb) : rd_ack_q);

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } xact_t;
   xact_t exp_q[$];

   typedef struct {
      logic [31:0] base;
      logic [11:0] n;
      logic [31:0] seed;
      logic [31:0] mask;
      logic [15:0] exp_err;
      logic [31:0] exp_ferr;
      bit          poke;
   } vec_t;
   vec_t tbl [6];

   int n_vec = 0;
   int n_err = 0;
   int cyc_total = 0;
   int rd_acks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle and check the bus as seen away from the clock edge.
   task automatic tick();
      xact_t e;
      @(negedge clk);
      if (wb_cyc) cyc_total++;
      chk("sel_stb_vs_cyc", {27'b0, wb_stb, wb_sel}, wb_cyc ? 32'h1F : 32'h0);
      if (wb_cyc && wb_stb && wb_ack) begin
         if (!wb_we) rd_acks++;
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", {31'b0, wb_we}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("bus_we", {31'b0, wb_we}, {31'b0, e.we});
            chk("bus_adr", wb_adr, e.adr);
            if (e.we) chk("bus_wdat", wb_dat_ms, e.dat);
         end
      end
   endtask

   task automatic run(input vec_t v);
      int cyc0, cycles;
      logic [31:0] b;
      b = v.base & ~32'h3;
      cur_base = b;
      corrupt_mask = v.mask;
      for (int i = 0; i < int'(v.n); i++) exp_q.push_back('{1'b1, b + 32'(4 * i), v.seed + 32'(i)});
      for (int i = 0; i < int'(v.n); i++) exp_q.push_back('{1'b0, b + 32'(4 * i), 32'h0});
      cyc0 = cyc_total;
      base_adr = v.base;
      nwords = v.n;
      seed = v.seed;
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 1;
      while (!done && cycles < 2000) begin
         if (v.poke && cycles == 3) begin
            start = 1'b1;
            nwords = 12'd1;
            base_adr = 32'h9000;
         end
         tick();
         start = 1'b0;
         cycles++;
      end
      chk("done_seen", {31'b0, done}, 32'h1);
      chk("latency", 32'(cycles), (v.n == 0) ? 32'd1 : 32'(2 * int'(v.n) + 3));
      chk("busy_in_fin", {31'b0, busy}, 32'h1);
      chk("cyc_cycles", 32'(cyc_total - cyc0), (v.n == 0) ? 32'd0 : 32'(2 * int'(v.n) + 1));
      chk("err_cnt", {16'b0, err_cnt}, {16'b0, v.exp_err});
      chk("first_err_adr", first_err_adr, v.exp_ferr);
      chk("timeout_clear", {31'b0, timeout}, 32'h0);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      // a start coinciding with the done cycle must be ignored
      if (v.poke) start = 1'b1;
      tick();
      start = 1'b0;
      chk("idle_busy", {31'b0, busy}, 32'h0);
      chk("idle_done", {31'b0, done}, 32'h0);
   endtask

   initial begin
      int cyc0, cycles;
      vec_t v;
      rst_n = 1'b0; start = 1'b0; base_adr = '0; nwords = '0; seed = '0;
      no_ack = 1'b0; cur_base = '0; corrupt_mask = '0;

      tbl[0] = '{32'h0000_0100, 12'd4, 32'hA5A5_0000, 32'h0,  16'd0, 32'h0,        1'b1};
      tbl[1] = '{32'h0000_0200, 12'd4, 32'h1234_0000, 32'hC,  16'd2, 32'h0000_0208, 1'b0};
      tbl[2] = '{32'h0000_0000, 12'd0, 32'h0,         32'h0,  16'd0, 32'h0,        1'b1};
      tbl[3] = '{32'hFFFF_FFF8, 12'd4, 32'hFFFF_FFFE, 32'h0,  16'd0, 32'h0,        1'b0};
      tbl[4] = '{32'h0000_0303, 12'd3, 32'h0000_0007, 32'h1,  16'd1, 32'h0000_0300, 1'b0};
      tbl[5] = '{32'h0000_0400, 12'd6, 32'h5555_AAAA, 32'h3F, 16'd6, 32'h0000_0400, 1'b0};

      repeat (3) tick();
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_cyc", {31'b0, wb_cyc}, 32'h0);
      chk("rst_err_cnt", {16'b0, err_cnt}, 32'h0);
      chk("rst_timeout", {31'b0, timeout}, 32'h0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 6; k++) run(tbl[k]);

      // Silent slave: abort after TIMEOUT wait cycles
      no_ack = 1'b1;
      cyc0 = cyc_total;
      base_adr = 32'h500; nwords = 12'd2; seed = 32'h0; start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 1;
      while (!done && cycles < 1000) begin
         tick();
         cycles++;
      end
      chk("to_done", {31'b0, done}, 32'h1);
      chk("to_latency", 32'(cycles), 32'd256);
      chk("to_cyc_cycles", 32'(cyc_total - cyc0), 32'd255);
      chk("to_flag", {31'b0, timeout}, 32'h1);
      chk("to_err_cnt", {16'b0, err_cnt}, 32'h0);
      tick();
      chk("to_sticky", {31'b0, timeout}, 32'h1);
      chk("to_idle", {31'b0, busy}, 32'h0);
      no_ack = 1'b0;
      v = '{32'h0000_0700, 12'd2, 32'h0000_0010, 32'h0, 16'd0, 32'h0, 1'b0};
      run(v);

      // Reset in the middle of the read phase
      cur_base = 32'h600;
      corrupt_mask = 32'h1;
      for (int i = 0; i < 8; i++) exp_q.push_back('{1'b1, 32'h600 + 32'(4 * i), 32'hBEEF_0000 + 32'(i)});
      for (int i = 0; i < 8; i++) exp_q.push_back('{1'b0, 32'h600 + 32'(4 * i), 32'h0});
      cyc0 = rd_acks;
      base_adr = 32'h600; nwords = 12'd8; seed = 32'hBEEF_0000; start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 1;
      while ((rd_acks - cyc0) < 3 && cycles < 100) begin
         tick();
         cycles++;
      end
      chk("mid_read_acks", 32'(rd_acks - cyc0), 32'd3);
      chk("mid_err_cnt", {16'b0, err_cnt}, 32'h1);
      rst_n = 1'b0;
      tick();
      chk("mrst_cyc_stb", {30'b0, wb_cyc, wb_stb}, 32'h0);
      chk("mrst_we_sel", {27'b0, wb_we, wb_sel}, 32'h0);
      chk("mrst_adr", wb_adr, 32'h0);
      chk("mrst_dat", wb_dat_ms, 32'h0);
      chk("mrst_status", {28'b0, busy, done, timeout, 1'b0}, 32'h0);
      chk("mrst_err_cnt", {16'b0, err_cnt}, 32'h0);
      chk("mrst_first_err", first_err_adr, 32'h0);
      exp_q.delete();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mrst_no_done", {31'b0, done}, 32'h0);
      end
      v = '{32'h0000_0600, 12'd8, 32'h0BAD_F00D, 32'h0, 16'd0, 32'h0, 1'b0};
      run(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
